// File: rtl/sm_arith_pkg.sv
// Shared definitions for the sign-magnitude arithmetic blocks.
//   sm_op_t       : effective operation chosen after folding the sign of B
//   sm_word_t     : generic sign-magnitude word; the magnitude field is sized
//                   for the widest supported operand and narrower users
//                   zero-extend into it
//   sm_normalise  : returns the canonical sign of a word (zero is always +)
//   SM_STAGES_MIN/MAX : legal pipeline depth range
package sm_arith_pkg;

   localparam int SM_STAGES_MIN = 1;
   localparam int SM_STAGES_MAX = 4;
   localparam int SM_WIDTH_MAX  = 64;

   typedef enum logic {
      ADD = 1'b0,
      SUB = 1'b1
   } sm_op_t;

   typedef struct packed {
      logic                    sign;
      logic [SM_WIDTH_MAX-1:0] mag;
   } sm_word_t;

   // A zero magnitude never carries a negative sign.
   function automatic logic sm_normalise(input sm_word_t w);
      return w.sign & (w.mag != '0);
   endfunction

endpackage

// File: rtl/sm_addsub_core.sv
// Combinational datapath of the sign-magnitude adder/subtractor, split in two
// halves so the caller can place pipeline registers between them.
//   pre half : a_mag/a_sign, b_mag/b_sign, sub  ->  pre_op, pre_sign,
//              pre_big, pre_small (operands ordered so big >= small when
//              subtracting, plus the sign the result will carry)
//   post half: post_op, post_sign, post_big, post_small  ->  s_mag, s_sign, ovf
//              (add or subtract, saturate/wrap, zero-sign clearing)
module sm_addsub_core
   import sm_arith_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter bit SAT   = 1'b1
)
(
   input  logic [WIDTH-1:0] a_mag,
   input  logic             a_sign,
   input  logic [WIDTH-1:0] b_mag,
   input  logic             b_sign,
   input  logic             sub,
   output sm_op_t           pre_op,
   output logic             pre_sign,
   output logic [WIDTH-1:0] pre_big,
   output logic [WIDTH-1:0] pre_small,
   input  sm_op_t           post_op,
   input  logic             post_sign,
   input  logic [WIDTH-1:0] post_big,
   input  logic [WIDTH-1:0] post_small,
   output logic [WIDTH-1:0] s_mag,
   output logic             s_sign,
   output logic             ovf
);

   logic             eb;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] diff;
   sm_word_t         raw_word;

   // Subtraction is addition with B's sign flipped.
   assign eb = b_sign ^ sub;

   // Differing signs become a magnitude subtraction; swap so the larger
   // magnitude is the minuend and the result takes that operand's sign.
   always_comb begin
      pre_op    = ADD;
      pre_sign  = a_sign;
      pre_big   = a_mag;
      pre_small = b_mag;
      if (a_sign != eb) begin
         pre_op = SUB;
         if (a_mag < b_mag) begin
            pre_sign  = eb;
            pre_big   = b_mag;
            pre_small = a_mag;
         end
      end
   end

   assign sum  = {1'b0, post_big} + {1'b0, post_small};
   assign diff = post_big - post_small;

   always_comb begin
      ovf           = 1'b0;
      raw_word.sign = post_sign;
      raw_word.mag  = '0;
      if (post_op == ADD) begin
         ovf = sum[WIDTH];
         if (sum[WIDTH] && SAT)
            raw_word.mag[WIDTH-1:0] = '1;
         else
            raw_word.mag[WIDTH-1:0] = sum[WIDTH-1:0];
      end else begin
         raw_word.mag[WIDTH-1:0] = diff;
      end
      s_mag  = raw_word.mag[WIDTH-1:0];
      s_sign = sm_normalise(raw_word);
   end

endmodule

// File: rtl/sm_addsub_pipe.sv
// Pipelined, elastic sign-magnitude adder/subtractor.
//   clk, reset            : clock and synchronous active-high reset
//   in_valid / in_ready   : input handshake (in_ready is combinational from
//                           out_ready through the stage valid chain)
//   a_mag, a_sign, b_mag, b_sign, sub : operands and add(0)/sub(1) select
//   out_valid / out_ready : output handshake
//   s_mag, s_sign, ovf    : normalised result and magnitude-overflow flag
// Stage 0 captures the compare/swap decision, middle stages only retime it,
// the last stage captures the final result. With one stage everything is
// combinational ahead of the single register.
module sm_addsub_pipe
   import sm_arith_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2,
   parameter bit SAT    = 1'b1
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_mag,
   input  logic             a_sign,
   input  logic [WIDTH-1:0] b_mag,
   input  logic             b_sign,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s_mag,
   output logic             s_sign,
   output logic             ovf
);

   localparam int PW = 2*WIDTH + 2;

   if (STAGES < SM_STAGES_MIN || STAGES > SM_STAGES_MAX ||
       WIDTH < 2 || WIDTH > SM_WIDTH_MAX) begin : g_param_check
      $error("sm_addsub_pipe: STAGES must be 1..4 and WIDTH 2..64");
   end

   sm_op_t            pre_op;
   sm_op_t            post_op;
   logic              post_op_bit;
   logic              pre_sign;
   logic              post_sign;
   logic [WIDTH-1:0]  pre_big;
   logic [WIDTH-1:0]  pre_small;
   logic [WIDTH-1:0]  post_big;
   logic [WIDTH-1:0]  post_small;
   logic [WIDTH-1:0]  res_mag;
   logic              res_sign;
   logic              res_ovf;
   logic [PW-1:0]     pre_word;
   logic [PW-1:0]     post_word;
   logic [STAGES-1:0] valid_reg;
   logic [STAGES-1:0] valid_up;
   logic [STAGES:0]   ready;
   logic [WIDTH-1:0]  s_mag_reg;
   logic              s_sign_reg;
   logic              ovf_reg;

   sm_addsub_core #(.WIDTH(WIDTH), .SAT(SAT)) u_core (
      .a_mag      (a_mag),
      .a_sign     (a_sign),
      .b_mag      (b_mag),
      .b_sign     (b_sign),
      .sub        (sub),
      .pre_op     (pre_op),
      .pre_sign   (pre_sign),
      .pre_big    (pre_big),
      .pre_small  (pre_small),
      .post_op    (post_op),
      .post_sign  (post_sign),
      .post_big   (post_big),
      .post_small (post_small),
      .s_mag      (res_mag),
      .s_sign     (res_sign),
      .ovf        (res_ovf)
   );

   assign pre_word = {pre_op, pre_sign, pre_big, pre_small};
   assign {post_op_bit, post_sign, post_big, post_small} = post_word;
   assign post_op = sm_op_t'(post_op_bit);

   // A stage may load when it is empty or its content moves on this cycle.
   // Evaluated top-down in one process so the chain is a plain ripple.
   always_comb begin
      ready         = '0;
      ready[STAGES] = out_ready;
      for (int k = STAGES-1; k >= 0; k--)
         ready[k] = !valid_reg[k] || ready[k+1];
   end

   always_comb begin
      valid_up    = '0;
      valid_up[0] = in_valid;
      for (int k = 1; k < STAGES; k++)
         valid_up[k] = valid_reg[k-1];
   end

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_valid
      always_ff @(posedge clk) begin
         if (reset)
            valid_reg[gi] <= 1'b0;
         else if (ready[gi])
            valid_reg[gi] <= valid_up[gi];
      end
   end

   if (STAGES == 1) begin : g_direct
      assign post_word = pre_word;
   end else begin : g_retime
      logic [PW-1:0] pre_reg [STAGES-1];
      for (genvar gi = 0; gi < STAGES-1; gi++) begin : g_pre
         logic [PW-1:0] load_word;
         if (gi == 0) begin : g_src_in
            assign load_word = pre_word;
         end else begin : g_src_prev
            assign load_word = pre_reg[gi-1];
         end
         // Data only moves with a valid transaction so held words stay put.
         always_ff @(posedge clk) begin
            if (reset)
               pre_reg[gi] <= '0;
            else if (ready[gi] && valid_up[gi])
               pre_reg[gi] <= load_word;
         end
      end
      assign post_word = pre_reg[STAGES-2];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s_mag_reg  <= '0;
         s_sign_reg <= 1'b0;
         ovf_reg    <= 1'b0;
      end else if (ready[STAGES-1] && valid_up[STAGES-1]) begin
         s_mag_reg  <= res_mag;
         s_sign_reg <= res_sign;
         ovf_reg    <= res_ovf;
      end
   end

   assign in_ready  = ready[0];
   assign out_valid = valid_reg[STAGES-1];
   assign s_mag     = s_mag_reg;
   assign s_sign    = s_sign_reg;
   assign ovf       = ovf_reg;

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Self-checking bench: four instances (STAGES/SAT variants, WIDTH=8) share one
// input stream; each has its own scoreboard of expected {ovf,sign,mag} words.
module tb_sm_addsub_pipe;

   localparam int STG_T [4] = '{2, 2, 1, 4};
   localparam bit SAT_T [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic [7:0] a_mag;
   logic       a_sign;
   logic [7:0] b_mag;
   logic       b_sign;
   logic       sub;
   logic       out_ready;
   logic       lat_chk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference result {ovf, sign, mag} using plain integer arithmetic.
   function automatic logic [9:0] model(input bit as, input logic [7:0] am,
                                        input bit bs, input logic [7:0] bm,
                                        input bit sb, input bit sat);
      bit          eb;
      int          sum;
      logic [7:0]  m;
      bit          s;
      bit          o;
      eb = bs ^ sb;
      o  = 1'b0;
      if (as == eb) begin
         sum = int'(am) + int'(bm);
         s   = as;
         if (sum > 255) begin
            o = 1'b1;
            m = sat ? 8'd255 : 8'(sum - 256);
         end else begin
            m = 8'(sum);
         end
      end else if (am >= bm) begin
         m = am - bm;
         s = as;
      end else begin
         m = bm - am;
         s = eb;
      end
      if (m == 8'd0) s = 1'b0;
      return {o, s, m};
   endfunction

   for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      localparam int ST   = STG_T[gi];
      localparam bit SATP = SAT_T[gi];
      logic       in_ready;
      logic       out_valid;
      logic [7:0] s_mag;
      logic       s_sign;
      logic       ovf;
      logic [9:0] exp_q [$];
      int         cyc_q [$];
      logic [9:0] prev_out;
      logic [9:0] e;
      int         c;
      bit         prev_stall = 1'b0;
      int         pending = 0;

      sm_addsub_pipe #(.WIDTH(8), .STAGES(ST), .SAT(SATP)) u_dut (
         .clk       (clk),
         .reset     (reset),
         .in_valid  (in_valid),
         .in_ready  (in_ready),
         .a_mag     (a_mag),
         .a_sign    (a_sign),
         .b_mag     (b_mag),
         .b_sign    (b_sign),
         .sub       (sub),
         .out_valid (out_valid),
         .out_ready (out_ready),
         .s_mag     (s_mag),
         .s_sign    (s_sign),
         .ovf       (ovf)
      );

      always @(negedge clk) begin
         if (reset) begin
            exp_q.delete();
            cyc_q.delete();
            prev_stall = 1'b0;
         end else begin
            if (prev_stall)
               check($sformatf("stall_hold%0d", gi), {22'd0, out_valid, ovf, s_sign, s_mag},
                     {22'd0, 1'b1, prev_out});
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  check($sformatf("unexpected_out%0d", gi), out_valid, 0);
               end else begin
                  e = exp_q.pop_front();
                  c = cyc_q.pop_front();
                  check($sformatf("result%0d", gi), {ovf, s_sign, s_mag}, e);
                  $display("dut%0d out: s=%s%0d ovf=%0d exp=%s%0d ovf=%0d", gi,
                           s_sign ? "-" : "+", s_mag, ovf, e[8] ? "-" : "+", e[7:0], e[9]);
                  if (lat_chk)
                     check($sformatf("latency%0d", gi), cyc - c, ST);
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {ovf, s_sign, s_mag};
            if (in_valid && in_ready) begin
               exp_q.push_back(model(a_sign, a_mag, b_sign, b_mag, sub, SATP));
               cyc_q.push_back(cyc);
            end
         end
         pending = exp_q.size();
      end
   end

   task automatic send(input bit as, input logic [7:0] am, input bit bs,
                       input logic [7:0] bm, input bit sb);
      int n;
      n        = 0;
      a_sign   = as;
      a_mag    = am;
      b_sign   = bs;
      b_mag    = bm;
      sub      = sb;
      in_valid = 1'b1;
      @(negedge clk);
      while (!g_dut[0].in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!g_dut[0].in_ready)
         check("in_ready_timeout", g_dut[0].in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      a_mag     = '0;
      a_sign    = 1'b0;
      b_mag     = '0;
      b_sign    = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b1;
      lat_chk   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("rst_out_valid", g_dut[0].out_valid, 0);
      check("rst_in_ready", g_dut[0].in_ready, 1);
      check("rst_s_mag", g_dut[0].s_mag, 0);
      check("rst_s_sign", g_dut[0].s_sign, 0);
      check("rst_ovf", g_dut[0].ovf, 0);
      check("rst_in_ready_s4", g_dut[3].in_ready, 1);

      // Directed arithmetic cases.
      send(1'b0, 8'd5,   1'b0, 8'd3,   1'b0);
      send(1'b0, 8'd3,   1'b0, 8'd5,   1'b1);
      send(1'b1, 8'd3,   1'b1, 8'd5,   1'b1);
      send(1'b1, 8'd7,   1'b0, 8'd7,   1'b0);
      send(1'b1, 8'd0,   1'b1, 8'd0,   1'b0);
      send(1'b1, 8'd0,   1'b1, 8'd0,   1'b1);
      send(1'b0, 8'd200, 1'b0, 8'd100, 1'b0);
      send(1'b1, 8'd200, 1'b0, 8'd100, 1'b1);
      send(1'b0, 8'd255, 1'b0, 8'd1,   1'b0);
      send(1'b1, 8'd0,   1'b0, 8'd9,   1'b0);
      idle(6);

      // Random back-to-back stream.
      repeat (24)
         send(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
      idle(8);

      // Back-pressure: fill the 2-stage pipe, stall, then drain.
      lat_chk   = 1'b0;
      out_ready = 1'b0;
      send(1'b0, 8'd10, 1'b0, 8'd1, 1'b0);
      send(1'b0, 8'd20, 1'b1, 8'd2, 1'b0);
      check("full_in_ready", g_dut[0].in_ready, 0);
      @(posedge clk);
      #1;
      check("full_in_ready2", g_dut[0].in_ready, 0);
      check("full_out_valid", g_dut[0].out_valid, 1);
      out_ready = 1'b1;
      send(1'b1, 8'd30, 1'b0, 8'd3,   1'b1);
      send(1'b0, 8'd40, 1'b0, 8'd250, 1'b0);
      send(1'b1, 8'd50, 1'b1, 8'd50,  1'b1);
      send(1'b0, 8'd60, 1'b1, 8'd6,   1'b1);
      idle(10);
      lat_chk = 1'b1;
      check("drain_q0", g_dut[0].pending, 0);
      check("drain_q1", g_dut[1].pending, 0);
      check("drain_q2", g_dut[2].pending, 0);
      check("drain_q3", g_dut[3].pending, 0);

      // Reset with two transactions in flight: both must vanish.
      out_ready = 1'b0;
      send(1'b0, 8'd11, 1'b0, 8'd22, 1'b0);
      send(1'b1, 8'd33, 1'b0, 8'd44, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("flush_valid0", g_dut[0].out_valid, 0);
      check("flush_valid1", g_dut[1].out_valid, 0);
      check("flush_valid2", g_dut[2].out_valid, 0);
      check("flush_valid3", g_dut[3].out_valid, 0);
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         check("flush_quiet", g_dut[0].out_valid, 0);
      end

      // Latency again after reset.
      send(1'b0, 8'd5, 1'b0, 8'd3, 1'b0);
      idle(8);
      check("end_q0", g_dut[0].pending, 0);
      check("end_q2", g_dut[2].pending, 0);
      check("end_q3", g_dut[3].pending, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
